// File: rtl/weight_stream_pkg.sv
// Shared types and width helpers for the weight streaming blocks.
// Beat and address widths are derived here so every block agrees.
package weight_stream_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } wrb_state_t;

  localparam int DEF_PRECISION_0 = 16;
  localparam int DEF_PRECISION_1 = 3;

  function automatic int beat_w(input int p, input int w);
    return p * w;
  endfunction

  // Array index width; a single-entry array still needs one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_replay_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array and read register are never reset.
module weight_replay_mem
  import weight_stream_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = 16,
  parameter int IW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [IW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_replay_buffer.sv
// Captures one weight matrix into local RAM, then replays it
// to the consumer REPLAY times (0 = forever) with last flags.
module weight_replay_buffer #(
  parameter int PRECISION_0       = weight_stream_pkg::DEF_PRECISION_0,
  parameter int PRECISION_1       = weight_stream_pkg::DEF_PRECISION_1,
  parameter int PARALLELISM_DIM_0 = 1,
  parameter int PARALLELISM_DIM_1 = 1,
  parameter int DEPTH             = 32,
  parameter int REPLAY            = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRECISION_0-1:0] data_in
    [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0],
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [PRECISION_0-1:0] data_out
    [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0],
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   data_out_last,
  output logic                   filled
);

  localparam int P  = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int BW = weight_stream_pkg::beat_w(P, PRECISION_0);
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = weight_stream_pkg::addr_w(DEPTH);
  localparam int PW = $clog2(REPLAY + 1) + 1;
  localparam bit FINITE = (REPLAY > 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_PASS =
    FINITE ? PW'(REPLAY - 1) : '0;
  localparam logic [PW-1:0] PASS_MAX = '1;

  if (DEPTH < 1 || PRECISION_1 > PRECISION_0) begin : g_bad_cfg
    $error("weight_replay_buffer: bad parameters");
  end

  weight_stream_pkg::wrb_state_t r_state;
  weight_stream_pkg::wrb_state_t w_state_nxt;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [PW-1:0] r_pass_cnt;
  logic [PW-1:0] r_rd_pass;
  logic          r_rd_pend;
  logic          r_valid;
  logic          r_last;

  logic [BW-1:0] w_wdata;
  logic [BW-1:0] w_rdata;
  logic          w_we;
  logic          w_re;
  logic          w_hs;
  logic          w_wr_last;
  logic          w_rd_wrap;
  logic          w_pass_end;
  logic          w_final;

  always_ff @(posedge clk) begin
    if (rst) r_state <= weight_stream_pkg::FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    data_in_ready = 1'b0;
    w_we          = 1'b0;
    w_re          = 1'b0;
    w_hs          = r_valid && data_out_ready;
    w_wr_last     = (r_wr_ptr == LAST_IDX);
    w_rd_wrap     = (r_rd_ptr == LAST_IDX);
    w_pass_end    = w_hs && r_last;
    w_final       = FINITE && w_pass_end &&
                    (r_pass_cnt == LAST_PASS);
    unique case (r_state)
      weight_stream_pkg::FILL: begin
        data_in_ready = 1'b1;
        w_we          = data_in_valid;
        if (w_we && w_wr_last)
          w_state_nxt = weight_stream_pkg::REPLAY;
      end
      weight_stream_pkg::REPLAY: begin
        w_re = r_rd_pend && (!r_valid || data_out_ready);
        if (w_final)
          w_state_nxt = weight_stream_pkg::FILL;
      end
      default: w_state_nxt = weight_stream_pkg::FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_wr_ptr <= '0;
    else if (w_we)
      r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + AW'(1);
  end

  // The read side tracks its own pass count so the last read
  // can be withheld before the consumer has caught up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_rd_pass <= '0;
      r_rd_pend <= 1'b0;
    end else if (w_re) begin
      r_rd_ptr <= w_rd_wrap ? '0 : r_rd_ptr + AW'(1);
      if (w_rd_wrap) begin
        if (r_rd_pass != PASS_MAX)
          r_rd_pass <= r_rd_pass + PW'(1);
        if (FINITE && r_rd_pass == LAST_PASS)
          r_rd_pend <= 1'b0;
      end
    end else if (w_we && w_wr_last) begin
      r_rd_ptr  <= '0;
      r_rd_pass <= '0;
      r_rd_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_pass_cnt <= '0;
    else if (w_final)
      r_pass_cnt <= '0;
    else if (w_pass_end && r_pass_cnt != PASS_MAX)
      r_pass_cnt <= r_pass_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_re) begin
      r_valid <= 1'b1;
      r_last  <= w_rd_wrap;
    end else if (w_hs) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < P; i++)
      w_wdata[i*PRECISION_0 +: PRECISION_0] = data_in[i];
  end

  weight_replay_mem #(
    .DEPTH (DEPTH),
    .W     (BW),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[IW-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr[IW-1:0]),
    .o_rdata (w_rdata)
  );

  // RAM read register is unreset, so mask it until a beat is live.
  always_comb begin
    for (int i = 0; i < P; i++)
      data_out[i] = r_valid ?
        w_rdata[i*PRECISION_0 +: PRECISION_0] : '0;
  end

  assign data_out_valid = r_valid;
  assign data_out_last  = r_last;
  assign filled = (r_state != weight_stream_pkg::FILL);

endmodule

// File: tb/tb_weight_replay_buffer.sv
// Directed bench for weight_replay_buffer across three
// configurations sharing one clock.
module tb_weight_replay_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A: DEPTH=4 REPLAY=2 P=1
  logic        a_rst, a_iv, a_ir, a_ov, a_ordy, a_ol, a_fil;
  logic [15:0] a_id [0:0];
  logic [15:0] a_od [0:0];

  weight_replay_buffer #(
    .DEPTH(4), .REPLAY(2)
  ) u_a (
    .clk(clk), .rst(a_rst),
    .data_in(a_id), .data_in_valid(a_iv), .data_in_ready(a_ir),
    .data_out(a_od), .data_out_valid(a_ov),
    .data_out_ready(a_ordy), .data_out_last(a_ol), .filled(a_fil)
  );

  // B: DEPTH=3 REPLAY=0 P=1
  logic        b_rst, b_iv, b_ir, b_ov, b_ordy, b_ol, b_fil;
  logic [15:0] b_id [0:0];
  logic [15:0] b_od [0:0];

  weight_replay_buffer #(
    .DEPTH(3), .REPLAY(0)
  ) u_b (
    .clk(clk), .rst(b_rst),
    .data_in(b_id), .data_in_valid(b_iv), .data_in_ready(b_ir),
    .data_out(b_od), .data_out_valid(b_ov),
    .data_out_ready(b_ordy), .data_out_last(b_ol), .filled(b_fil)
  );

  // C: DEPTH=1 REPLAY=3 P=4
  logic        c_rst, c_iv, c_ir, c_ov, c_ordy, c_ol, c_fil;
  logic [15:0] c_id [3:0];
  logic [15:0] c_od [3:0];

  weight_replay_buffer #(
    .PARALLELISM_DIM_0(4), .DEPTH(1), .REPLAY(3)
  ) u_c (
    .clk(clk), .rst(c_rst),
    .data_in(c_id), .data_in_valid(c_iv), .data_in_ready(c_ir),
    .data_out(c_od), .data_out_valid(c_ov),
    .data_out_ready(c_ordy), .data_out_last(c_ol), .filled(c_fil)
  );

  logic [15:0] fvals [4];
  logic [15:0] got_d [$];
  logic        got_l [$];

  task automatic fill_a(input bit gap, output int fcyc,
                        output int lat);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < 4 && c < 50) begin
      a_iv = gap ? c[0] : 1'b1;
      a_id[0] = fvals[k];
      if (a_iv && a_ir) k++;
      c++;
      @(negedge clk);
    end
    a_iv = 1'b0;
    fcyc = c;
    chk("a_filled", a_fil, 1);
    chk("a_ir_drop", a_ir, 0);
    chk("a_no_early_v", a_ov, 0);
    lat = 1;
    while (!a_ov && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic collect_a(input int n, input bit tog,
                           output int used);
    int k;
    bit hold;
    logic [15:0] hd;
    logic hl;
    k = 0;
    used = 0;
    hold = 1'b0;
    hd = '0;
    hl = 1'b0;
    got_d.delete();
    got_l.delete();
    while (k < n && used < 200) begin
      if (hold) begin
        chk("a_hold_v", a_ov, 1);
        chk("a_hold_d", a_od[0], hd);
        chk("a_hold_l", a_ol, hl);
      end
      a_iv = 1'b1;
      a_id[0] = 16'hDEAD;
      a_ordy = tog ? (used % 2 == 0) : 1'b1;
      hold = 1'b0;
      if (a_ov && a_ordy) begin
        got_d.push_back(a_od[0]);
        got_l.push_back(a_ol);
        k++;
      end else if (a_ov) begin
        hold = 1'b1;
        hd = a_od[0];
        hl = a_ol;
      end
      used++;
      @(negedge clk);
    end
    a_iv = 1'b0;
    a_ordy = 1'b1;
    chk("a_beats", k, n);
  endtask

  task automatic check_seq(input int n);
    for (int i = 0; i < n; i++) begin
      chk("a_seq_d", (i < got_d.size()) ? got_d[i] : 16'hx,
          fvals[i % 4]);
      chk("a_seq_l", (i < got_l.size()) ? got_l[i] : 1'bx,
          (i % 4) == 3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, lat, used, k, c;
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_iv = 0; b_iv = 0; c_iv = 0;
    a_ordy = 1; b_ordy = 1; c_ordy = 1;
    a_id[0] = '0; b_id[0] = '0;
    for (int i = 0; i < 4; i++) c_id[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_v", a_ov, 0);
    chk("rst_l", a_ol, 0);
    chk("rst_fil", a_fil, 0);
    chk("rst_ir", a_ir, 1);
    chk("rst_d", a_od[0], 0);
    a_rst = 0; b_rst = 0; c_rst = 0;

    // test 1
    for (int i = 0; i < 4; i++) fvals[i] = 16'(i + 1);
    fill_a(1'b0, fc, lat);
    chk("t1_fill_cyc", fc, 4);
    chk("t1_lat", lat, 2);
    collect_a(8, 1'b0, used);
    chk("t1_b2b", used, 8);
    check_seq(8);
    chk("t1_v_end", a_ov, 0);
    chk("t1_refill", a_ir, 1);

    // test 2
    fill_a(1'b0, fc, lat);
    collect_a(8, 1'b1, used);
    chk("t2_cycles", used, 15);
    check_seq(8);
    chk("t2_v_end", a_ov, 0);

    // test 3
    fill_a(1'b1, fc, lat);
    chk("t3_fill_cyc", fc, 8);
    chk("t3_lat", lat, 2);
    collect_a(8, 1'b0, used);
    check_seq(8);

    // test 5
    fill_a(1'b0, fc, lat);
    collect_a(6, 1'b0, used);
    chk("t5_pre_d", a_od[0], 3);
    a_rst = 1;
    @(negedge clk);
    chk("t5_rst_v", a_ov, 0);
    chk("t5_rst_fil", a_fil, 0);
    chk("t5_rst_ir", a_ir, 1);
    chk("t5_rst_d", a_od[0], 0);
    a_rst = 0;
    for (int i = 0; i < 4; i++) fvals[i] = 16'(i + 5);
    fill_a(1'b0, fc, lat);
    chk("t5_lat", lat, 2);
    collect_a(8, 1'b0, used);
    check_seq(8);

    // test 4
    k = 0;
    c = 0;
    while (k < 3 && c < 20) begin
      b_iv = 1'b1;
      b_id[0] = 16'(7 + k);
      if (b_ir) k++;
      c++;
      @(negedge clk);
    end
    b_iv = 1'b0;
    chk("t4_fill_cyc", c, 3);
    c = 0;
    while (!b_ov && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("t4_lat", c, 1);
    k = 0;
    c = 0;
    while (k < 100 && c < 150) begin
      b_iv = 1'b1;
      if (b_ov) begin
        chk("t4_d", b_od[0], 16'(7 + k % 3));
        chk("t4_l", b_ol, (k % 3) == 2);
        k++;
      end
      chk("t4_ir", b_ir, 0);
      c++;
      @(negedge clk);
    end
    b_iv = 1'b0;
    chk("t4_cycles", c, 100);
    chk("t4_still_v", b_ov, 1);

    // test 6
    c_id[0] = 16'h000A;
    c_id[1] = 16'h000B;
    c_id[2] = 16'h000C;
    c_id[3] = 16'h000D;
    c_iv = 1'b1;
    chk("t6_ir", c_ir, 1);
    @(negedge clk);
    c_iv = 1'b0;
    chk("t6_fil", c_fil, 1);
    chk("t6_v0", c_ov, 0);
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk("t6_v", c_ov, 1);
      chk("t6_e0", c_od[0], 16'h000A);
      chk("t6_e1", c_od[1], 16'h000B);
      chk("t6_e2", c_od[2], 16'h000C);
      chk("t6_e3", c_od[3], 16'h000D);
      chk("t6_l", c_ol, 1);
      @(negedge clk);
    end
    chk("t6_v_end", c_ov, 0);
    chk("t6_refill", c_ir, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
